// File: rtl/key_debounce_irq_ctrl.sv
// ============================================================================
// key_debounce_irq_ctrl: push-button synchroniser/debouncer with press-edge
// capture, maskable level interrupt and an Avalon-MM slave (read latency 1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_debounce_irq_ctrl #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic                irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    // Terminal value is one below DEBOUNCE_CYCLES-1 because entering COUNTING costs an edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_RAW     = 2'd3;

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_t;

    logic [NUM_KEYS-1:0] key_norm;
    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync;
    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] irqmask;
    logic [NUM_KEYS-1:0] edgecapture;
    logic [NUM_KEYS-1:0] ec_clear;
    logic [31:0]         rd_next;
    logic                unused_inputs;

    assign unused_inputs = &{1'b0, read, writedata};

    // Released level maps to 0 so the reset value of the synchroniser is "released".
    assign key_norm = (ACTIVE_LOW != 0) ? ~key_in : key_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= key_norm;
            sync      <= sync_meta;
        end
    end

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
            deb_state_t       state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             stable_q, stable_d;
            logic             rise_d;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_q  <= ST_STABLE;
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q;
                stable_d = stable_q;
                rise_d   = 1'b0;
                case (state_q)
                    ST_STABLE: begin
                        cnt_d = '0;
                        if (sync[i] != stable_q) begin
                            state_d = ST_COUNTING;
                        end
                    end
                    ST_COUNTING: begin
                        if (sync[i] == stable_q) begin
                            cnt_d   = '0;
                            state_d = ST_STABLE;
                        end else if (cnt_q == CNT_LAST) begin
                            stable_d = sync[i];
                            rise_d   = sync[i];
                            cnt_d    = '0;
                            state_d  = ST_STABLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end
                endcase
            end

            assign stable[i] = stable_q;
            assign rise[i]   = rise_d;
        end
    endgenerate

    assign ec_clear = (write && (address == ADDR_EDGECAP)) ? writedata[NUM_KEYS-1:0] : '0;

    // A press landing on the same edge as a clear keeps its bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (write && (address == ADDR_IRQMASK)) begin
                irqmask <= writedata[NUM_KEYS-1:0];
            end
            edgecapture <= (edgecapture & ~ec_clear) | rise;
        end
    end

    assign irq = |(edgecapture & irqmask);

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[NUM_KEYS-1:0] = stable;
            ADDR_IRQMASK: rd_next[NUM_KEYS-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[NUM_KEYS-1:0] = edgecapture;
            ADDR_RAW:     rd_next[NUM_KEYS-1:0] = sync;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_irq_ctrl.sv
// ============================================================================
// tb_key_debounce_irq_ctrl: directed self-checking bench, DEBOUNCE_CYCLES=8.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_key_debounce_irq_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  key_in;
    logic        irq;

    int vectors;
    int miscompares;

    key_debounce_irq_ctrl #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (8),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .key_in    (key_in),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        read    = 1'b1;
        step();
        check(tag, readdata, exp);
        read    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        step();
        write     = 1'b0;
        writedata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        address     = 2'd0;
        read        = 1'b0;
        write       = 1'b0;
        writedata   = '0;
        key_in      = 4'hF;

        // Reset state
        steps(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;
        steps(3);
        rd(2'd0, 32'h0, "rst_data");
        rd(2'd1, 32'h0, "rst_irqmask");
        rd(2'd2, 32'h0, "rst_edgecap");
        rd(2'd3, 32'h0, "rst_raw");

        // 5-cycle glitch on key0 is rejected
        key_in = 4'hE;
        steps(5);
        key_in = 4'hF;
        steps(12);
        rd(2'd0, 32'h0, "glitch_data");
        rd(2'd2, 32'h0, "glitch_edgecap");
        check("glitch_irq", {31'd0, irq}, 32'h0);

        // Held press: stable updates at edge 10, seen on readdata after edge 11
        address = 2'd0;
        read    = 1'b1;
        key_in  = 4'hE;
        steps(10);
        check("press_edge10_not_yet", readdata, 32'h0);
        step();
        check("press_edge11_data", readdata, 32'h1);
        read = 1'b0;
        steps(9);
        rd(2'd2, 32'h1, "press_edgecap");
        check("press_irq_masked", {31'd0, irq}, 32'h0);
        rd(2'd3, 32'h1, "press_raw");

        // Clear, enable mask, release (not captured), press again
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h0, "clear_edgecap");
        rd(2'd0, 32'h1, "clear_data_kept");
        wr(2'd1, 32'h1);
        rd(2'd1, 32'h1, "mask_readback");
        key_in = 4'hF;
        steps(14);
        rd(2'd0, 32'h0, "release_data");
        rd(2'd2, 32'h0, "release_not_captured");
        check("release_irq", {31'd0, irq}, 32'h0);
        key_in = 4'hE;
        steps(14);
        check("press2_irq", {31'd0, irq}, 32'h1);
        rd(2'd2, 32'h1, "press2_edgecap");
        wr(2'd2, 32'h1);
        check("w1c_irq_drop", {31'd0, irq}, 32'h0);
        rd(2'd0, 32'h1, "w1c_data_kept");

        // Upper mask bits ignored; writes to DATA do not disturb the mask
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, 32'h0000_000F, "mask_width");
        wr(2'd0, 32'h0);
        rd(2'd1, 32'h0000_000F, "data_write_ignored");
        wr(2'd3, 32'h0);
        rd(2'd1, 32'h0000_000F, "raw_write_ignored");
        wr(2'd1, 32'h1);

        // Clear of bit2 on the very edge key2 is accepted: set wins
        key_in = 4'hA;
        steps(9);
        address   = 2'd2;
        writedata = 32'h4;
        write     = 1'b1;
        step();
        write     = 1'b0;
        writedata = '0;
        rd(2'd2, 32'h4, "set_wins_edgecap");
        rd(2'd0, 32'h5, "set_wins_data");
        check("mask_excludes_bit2", {31'd0, irq}, 32'h0);
        wr(2'd1, 32'h4);
        check("mask_bit2_irq", {31'd0, irq}, 32'h1);
        wr(2'd1, 32'h0);
        check("mask_clear_irq_drop", {31'd0, irq}, 32'h0);

        // Reset at cnt=5 mid-press, then a full debounce is needed again
        key_in = 4'hF;
        steps(14);
        key_in = 4'hD;
        steps(8);
        reset_n = 1'b0;
        address = 2'd1;
        step();
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;
        read    = 1'b1;
        step();
        check("post_reset_mask", readdata, 32'h0);
        address = 2'd0;
        steps(9);
        check("post_reset_edge10_not_yet", readdata, 32'h0);
        step();
        check("post_reset_edge11_data", readdata, 32'h2);
        read = 1'b0;
        rd(2'd2, 32'h2, "post_reset_edgecap");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
